control_store_sequencer: RTL and testbench



---
 rtl/control_store_sequencer_if.sv | 35 +++
 rtl/control_store_sequencer.sv | 112 +++++++++++
 tb/tb_control_store_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/control_store_sequencer_if.sv
// ---------------------------------------------------------------------------
// ControlStoreSequencerIf
// Bundles the branch-logic-to-sequencer signals and the sequencer outputs.
//   master : branch logic / microword side; drives sel, jump_addr, ir,
//            stall, ucall and uret, and observes the sequencer outputs.
//   slave  : the sequencer; consumes the selects and drives csar, ret_addr,
//            ret_valid, decode_strobe and illegal_sel.
// ---------------------------------------------------------------------------
interface control_store_sequencer_if #(
    parameter int AW = 11
);
    logic [1:0]    sel;
    logic [AW-1:0] jump_addr;
    logic [31:0]   ir;
    logic          stall;
    logic          ucall;
    logic          uret;
    logic [AW-1:0] csar;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic          decode_strobe;
    logic          illegal_sel;

    // The branch logic drives the selects and watches the address outputs
    modport master (
        output sel, jump_addr, ir, stall, ucall, uret,
        input  csar, ret_addr, ret_valid, decode_strobe, illegal_sel
    );

    // The sequencer consumes the selects and produces the address outputs
    modport slave (
        input  sel, jump_addr, ir, stall, ucall, uret,
        output csar, ret_addr, ret_valid, decode_strobe, illegal_sel
    );
endinterface

// File: rtl/control_store_sequencer.sv
// ---------------------------------------------------------------------------
// control_store_sequencer
// Forms the next control-store address every clock and holds it in CSAR.
// Supports NEXT / JUMP / DECODE sequencing, stall hold, a single-level
// microsubroutine call/return register and a sticky illegal-sequence flag.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : slave side of control_store_sequencer_if (selects in, CSAR,
//          return register, decode strobe and illegal flag out)
// ---------------------------------------------------------------------------
module control_store_sequencer #(
    parameter int            AW         = 11,
    parameter logic [AW-1:0] RESET_ADDR = 11'd0,
    parameter logic [AW-1:0] TRAP_ADDR  = 11'h7FF
) (
    input logic                      clk,
    input logic                      rst,
    control_store_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_NEXT   = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_DECODE = 2'b10,
        SEL_RSVD   = 2'b11
    } sel_e;

    logic [AW-1:0] csar_q, csar_d;
    logic [AW-1:0] ret_addr_q, ret_addr_d;
    logic          ret_valid_q, ret_valid_d;
    logic          decode_strobe_q, decode_strobe_d;
    logic          illegal_sel_q, illegal_sel_d;
    logic [AW-1:0] csar_inc;
    logic [AW-1:0] decode_addr;

    // The incremented address doubles as the NEXT target and the return
    // address saved by a call; it wraps naturally at the top of the store.
    // The decode entry point is MSB 1, op, op3/op2 field, then two zero
    // bits, giving each opcode a four-word slot in the upper half.
    assign csar_inc    = csar_q + AW'(1);
    assign decode_addr = AW'({1'b1, bus.ir[31:30], bus.ir[24:19], 2'b00});

    // Next-state selection. A stall freezes everything but still kills the
    // decode strobe; a return outranks the select and ignores any call bit;
    // a call is only honoured alongside a JUMP and simply overwrites any
    // address already saved. The illegal flag only ever gets set here.
    always_comb begin
        csar_d          = csar_q;
        ret_addr_d      = ret_addr_q;
        ret_valid_d     = ret_valid_q;
        decode_strobe_d = 1'b0;
        illegal_sel_d   = illegal_sel_q;
        if (!bus.stall) begin
            if (bus.uret) begin
                if (ret_valid_q) begin
                    csar_d      = ret_addr_q;
                    ret_valid_d = 1'b0;
                end else begin
                    csar_d        = TRAP_ADDR;
                    illegal_sel_d = 1'b1;
                end
            end else begin
                case (sel_e'(bus.sel))
                    SEL_NEXT: begin
                        csar_d = csar_inc;
                    end
                    SEL_JUMP: begin
                        csar_d = bus.jump_addr;
                        if (bus.ucall) begin
                            ret_addr_d  = csar_inc;
                            ret_valid_d = 1'b1;
                        end
                    end
                    SEL_DECODE: begin
                        csar_d          = decode_addr;
                        decode_strobe_d = 1'b1;
                    end
                    default: begin
                        csar_d        = TRAP_ADDR;
                        illegal_sel_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // State register. Reset wins over everything, so any pending return
    // and the sticky error are discarded when rst is seen on an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            csar_q          <= RESET_ADDR;
            ret_addr_q      <= '0;
            ret_valid_q     <= 1'b0;
            decode_strobe_q <= 1'b0;
            illegal_sel_q   <= 1'b0;
        end else begin
            csar_q          <= csar_d;
            ret_addr_q      <= ret_addr_d;
            ret_valid_q     <= ret_valid_d;
            decode_strobe_q <= decode_strobe_d;
            illegal_sel_q   <= illegal_sel_d;
        end
    end

    assign bus.csar          = csar_q;
    assign bus.ret_addr      = ret_addr_q;
    assign bus.ret_valid     = ret_valid_q;
    assign bus.decode_strobe = decode_strobe_q;
    assign bus.illegal_sel   = illegal_sel_q;

endmodule

// File: tb/tb_control_store_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_store_sequencer
// Drives the sequencer through its directed scenarios and a random run,
// predicting every cycle's outputs with a small behavioural model. Expected
// outputs are queued when a cycle is driven and compared once the DUT has
// clocked that cycle.
// ---------------------------------------------------------------------------
module tb_control_store_sequencer;

    localparam int         AW   = 11;
    localparam logic [10:0] RST_A = 11'd0;
    localparam logic [10:0] TRAP  = 11'h7FF;

    typedef struct packed {
        logic [10:0] csar;
        logic [10:0] retAddr;
        logic        retValid;
        logic        strobe;
        logic        illegal;
    } expect_t;

    logic clk;
    logic rst;
    control_store_sequencer_if #(.AW(AW)) bus ();

    control_store_sequencer #(
        .AW(AW), .RESET_ADDR(RST_A), .TRAP_ADDR(TRAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    expect_t     sbQueue[$];
    int          compareCount;
    int          mismatchCount;
    logic [10:0] mCsar;
    logic [10:0] mRetAddr;
    logic        mRetValid;
    logic        mStrobe;
    logic        mIllegal;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural prediction of one clock edge, written from the
    // sequencing rules rather than from the RTL structure
    task automatic predict(input logic r, input logic [1:0] s, input logic [10:0] j,
                           input logic [31:0] instr, input logic st,
                           input logic uc, input logic ur);
        logic [10:0] nextSeq;
        nextSeq = mCsar + 11'd1;
        if (r) begin
            mCsar = RST_A; mRetAddr = 11'd0; mRetValid = 1'b0;
            mStrobe = 1'b0; mIllegal = 1'b0;
        end else if (st) begin
            mStrobe = 1'b0;
        end else if (ur) begin
            mStrobe = 1'b0;
            if (mRetValid) begin
                mCsar = mRetAddr; mRetValid = 1'b0;
            end else begin
                mCsar = TRAP; mIllegal = 1'b1;
            end
        end else begin
            mStrobe = 1'b0;
            if (s == 2'b00) mCsar = nextSeq;
            else if (s == 2'b01) begin
                if (uc) begin
                    mRetAddr = nextSeq; mRetValid = 1'b1;
                end
                mCsar = j;
            end else if (s == 2'b10) begin
                mCsar = {1'b1, instr[31:30], instr[24:19], 2'b00};
                mStrobe = 1'b1;
            end else begin
                mCsar = TRAP; mIllegal = 1'b1;
            end
        end
    endtask

    // Drive one cycle, queue its expectation, clock it, then pop and compare
    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [10:0] j,
                                 input logic [31:0] instr, input logic st,
                                 input logic uc, input logic ur);
        expect_t e;
        expect_t got;
        rst = r; bus.sel = s; bus.jump_addr = j; bus.ir = instr;
        bus.stall = st; bus.ucall = uc; bus.uret = ur;
        predict(r, s, j, instr, st, uc, ur);
        sbQueue.push_back('{mCsar, mRetAddr, mRetValid, mStrobe, mIllegal});
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        got = '{bus.csar, bus.ret_addr, bus.ret_valid, bus.decode_strobe, bus.illegal_sel};
        checkOutput("csar", 32'(got.csar), 32'(e.csar));
        checkOutput("ret_addr", 32'(got.retAddr), 32'(e.retAddr));
        checkOutput("ret_valid", 32'(got.retValid), 32'(e.retValid));
        checkOutput("decode_strobe", 32'(got.strobe), 32'(e.strobe));
        checkOutput("illegal_sel", 32'(got.illegal), 32'(e.illegal));
    endtask

    // Directed scenarios followed by a random run
    initial begin
        compareCount = 0; mismatchCount = 0;
        mCsar = '0; mRetAddr = '0; mRetValid = 1'b0; mStrobe = 1'b0; mIllegal = 1'b0;
        rst = 1'b1; bus.sel = 2'b00; bus.jump_addr = '0; bus.ir = '0;
        bus.stall = 1'b0; bus.ucall = 1'b0; bus.uret = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("reset_csar", 32'(bus.csar), 32'h0);
        checkOutput("reset_strobe", 32'(bus.decode_strobe), 32'h0);

        repeat (3) applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("next_x3", 32'(bus.csar), 32'h3);

        applyStimulus(0, 2'b01, 11'h7FF, 32'h0, 0, 0, 0);
        applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("wrap", 32'(bus.csar), 32'h0);

        applyStimulus(0, 2'b10, 11'h0, 32'h8200_4001, 0, 0, 0);
        checkOutput("decode_addr", 32'(bus.csar), 32'h600);
        checkOutput("decode_pulse", 32'(bus.decode_strobe), 32'h1);
        applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("decode_pulse_end", 32'(bus.decode_strobe), 32'h0);

        applyStimulus(0, 2'b10, 11'h0, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus(0, 2'b10, 11'h0, 32'h4108_0000, 0, 0, 0);
        checkOutput("b2b_decode_pulse", 32'(bus.decode_strobe), 32'h1);

        applyStimulus(0, 2'b01, 11'h010, 32'h0, 0, 0, 0);
        applyStimulus(0, 2'b01, 11'h200, 32'h0, 0, 1, 0);
        checkOutput("call_ret_addr", 32'(bus.ret_addr), 32'h011);
        applyStimulus(0, 2'b01, 11'h0AA, 32'h0, 0, 0, 1);
        checkOutput("return_csar", 32'(bus.csar), 32'h011);

        applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 1, 1);
        checkOutput("bad_return_trap", 32'(bus.csar), 32'h7FF);
        applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        applyStimulus(1, 2'b00, 11'h0, 32'h0, 0, 0, 0);

        applyStimulus(0, 2'b11, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("rsvd_illegal", 32'(bus.illegal_sel), 32'h1);
        repeat (2) applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 0, 0);
        checkOutput("illegal_sticky", 32'(bus.illegal_sel), 32'h1);

        applyStimulus(0, 2'b00, 11'h0, 32'h0, 0, 1, 0);
        repeat (3) applyStimulus(0, 2'b01, 11'h123, 32'h0, 1, 1, 1);
        applyStimulus(0, 2'b10, 11'h0, 32'h8200_4001, 1, 0, 0);
        checkOutput("stall_no_strobe", 32'(bus.decode_strobe), 32'h0);
        applyStimulus(0, 2'b01, 11'h123, 32'h0, 0, 0, 0);
        checkOutput("unstall_jump", 32'(bus.csar), 32'h123);

        applyStimulus(0, 2'b01, 11'h050, 32'h0, 0, 1, 0);
        applyStimulus(0, 2'b01, 11'h060, 32'h0, 0, 1, 0);
        checkOutput("call_overwrite", 32'(bus.ret_addr), 32'h051);
        applyStimulus(0, 2'b11, 11'h0, 32'h0, 0, 0, 0);
        applyStimulus(1, 2'b01, 11'h0, 32'h0, 0, 1, 1);
        checkOutput("rst_clears_rv", 32'(bus.ret_valid), 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] rs;
            rs = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 39) == 0), rs, 11'($urandom),
                          $urandom, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
